// File: rtl/uart_key_pacer.sv
// uart_key_pacer: FIFO between the uart receiver and the PET key mapper.
// It releases one byte per GAP_CYCLES clocks so that the keyboard scan keeps up.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   in_data     - received byte
//   in_strobe   - push request for in_data
//   flush       - synchronous clear of the FIFO, the FSM and overflow
//   out_data    - registered byte for the key mapper
//   out_strobe  - one-cycle pulse while out_data is valid
//   overflow    - sticky flag, set when a byte was dropped because the FIFO was full
//   count       - FIFO occupancy, 0 .. 2^ADDR_BITS
module uart_key_pacer #(
    parameter int ADDR_BITS  = 4,
    parameter int GAP_CYCLES = 2500000,
    parameter bit DROP_LF    = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_strobe,
    input  logic               flush,
    output logic [7:0]         out_data,
    output logic               out_strobe,
    output logic               overflow,
    output logic [ADDR_BITS:0] count
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS+1)'(DEPTH);
    localparam logic [23:0] GAP_LOAD = 24'(GAP_CYCLES - 2);

    typedef enum logic {
        IDLE,
        GAP
    } state_t;

    state_t state, state_nxt;
    logic [23:0] gap_cnt, gap_nxt;

    logic [7:0]           mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;

    logic empty;
    logic full;
    logic want;
    logic push;
    logic pop;
    logic drop;
    logic clr;

    assign clr   = reset | flush;
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // is still accepted then.
    always_comb begin
        want = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        drop = 1'b0;
        if (!clr) begin
            want = in_strobe && !(DROP_LF && in_data == 8'h0A);
            pop  = (state == IDLE) && !empty;
            push = want && (!full || pop);
            drop = want && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // The counter is loaded with GAP_CYCLES-2 so that pops are GAP_CYCLES
    // apart: one cycle in IDLE plus GAP_CYCLES-1 cycles in GAP.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = GAP;
                    gap_nxt   = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt - 24'd1;
                end
            end
        endcase
        if (flush) begin
            state_nxt = IDLE;
            gap_nxt   = '0;
        end
    end

    // The memory has no reset and is read asynchronously.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            out_strobe <= 1'b0;
            if (reset) begin
                out_data <= 8'h00;
            end
        end else begin
            out_strobe <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                out_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_key_pacer.sv
// Directed testbench for uart_key_pacer with GAP_CYCLES=8 and depth 4.
// A second instance with DROP_LF=0 shares the same stimulus.
module tb_uart_key_pacer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_strobe = 1'b0;
    logic       flush = 1'b0;

    logic [7:0] d1, d2;
    logic       s1, s2, o1, o2;
    logic [2:0] c1, c2;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int cmax = 0;
    int dbl = 0;
    int ts;
    bit p1 = 1'b0;
    bit p2 = 1'b0;

    int         q1t[$];
    logic [7:0] q1d[$];
    int         q2t[$];
    logic [7:0] q2d[$];

    uart_key_pacer #(.ADDR_BITS(2), .GAP_CYCLES(8), .DROP_LF(1'b1)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_strobe(in_strobe),
        .flush(flush), .out_data(d1), .out_strobe(s1), .overflow(o1),
        .count(c1)
    );

    uart_key_pacer #(.ADDR_BITS(2), .GAP_CYCLES(8), .DROP_LF(1'b0)) dut_nf (
        .clk(clk), .reset(reset), .in_data(in_data), .in_strobe(in_strobe),
        .flush(flush), .out_data(d2), .out_strobe(s2), .overflow(o2),
        .count(c2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s1) begin
            q1t.push_back(cyc);
            q1d.push_back(d1);
        end
        if (s2) begin
            q2t.push_back(cyc);
            q2d.push_back(d2);
        end
        if ((s1 && p1) || (s2 && p2)) dbl++;
        p1 = s1;
        p2 = s2;
        if (int'(c1) > cmax) cmax = int'(c1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic s,
                         input logic f, input logic r);
        in_data   = d;
        in_strobe = s;
        flush     = f;
        reset     = r;
        @(posedge clk);
        #1;
        in_strobe = 1'b0;
        flush     = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_log();
        q1t.delete();
        q1d.delete();
        q2t.delete();
        q2d.delete();
        cmax = 0;
    endtask

    initial begin
        tick(2);
        chk("rst_data", d1, 8'h00);
        chk("rst_strobe", s1, 0);
        chk("rst_ovf", o1, 0);
        chk("rst_count", c1, 0);
        reset = 1'b0;
        tick(3);
        chk("post_rst_strobe", s1, 0);
        chk("post_rst_count", c1, 0);

        // 1: single byte
        clr_log();
        ts = cyc;
        drive(8'h41, 1, 0, 0);
        chk("s1_count1", c1, 1);
        tick(1);
        chk("s1_strobe", s1, 1);
        chk("s1_data", d1, 8'h41);
        chk("s1_count0", c1, 0);
        tick(20);
        chk("s1_npulse", q1t.size(), 1);
        chk("s1_lat", q1t[0] - ts, 2);

        // 2: burst pacing
        clr_log();
        ts = cyc;
        drive(8'h31, 1, 0, 0);
        drive(8'h32, 1, 0, 0);
        drive(8'h33, 1, 0, 0);
        tick(30);
        chk("s2_npulse", q1t.size(), 3);
        chk("s2_t0", q1t[0] - ts, 2);
        chk("s2_t1", q1t[1] - ts, 10);
        chk("s2_t2", q1t[2] - ts, 18);
        chk("s2_d0", q1d[0], 8'h31);
        chk("s2_d1", q1d[1], 8'h32);
        chk("s2_d2", q1d[2], 8'h33);
        chk("s2_cmax", cmax, 2);
        chk("s2_ovf", o1, 0);

        // 3: overflow and pointer wrap
        clr_log();
        ts = cyc;
        for (int i = 0; i < 6; i++) drive(8'(i), 1, 0, 0);
        chk("s3_ovf_set", o1, 1);
        chk("s3_full", c1, 4);
        tick(45);
        chk("s3_npulse", q1t.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("s3_d%0d", i), q1d[i], 8'(i));
            chk($sformatf("s3_t%0d", i), q1t[i] - ts, 2 + 8 * i);
        end
        chk("s3_ovf_sticky", o1, 1);
        drive(8'h00, 0, 1, 0);
        chk("s3_flush_ovf", o1, 0);

        // 4: push into a full FIFO in the cycle of a pop
        clr_log();
        ts = cyc;
        for (int i = 0; i < 5; i++) drive(8'hA0 + 8'(i), 1, 0, 0);
        tick(4);
        chk("s4_full", c1, 4);
        drive(8'hA5, 1, 0, 0);
        chk("s4_count", c1, 4);
        chk("s4_ovf", o1, 0);
        chk("s4_strobe", s1, 1);
        chk("s4_data", d1, 8'hA1);
        tick(40);
        chk("s4_npulse", q1t.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("s4_d%0d", i), q1d[i], 8'hA0 + 8'(i));
        chk("s4_tlast", q1t[5] - ts, 42);

        // 5: line-feed filter
        tick(10);
        clr_log();
        drive(8'h0D, 1, 0, 0);
        drive(8'h0A, 1, 0, 0);
        tick(15);
        chk("s5_npulse", q1t.size(), 1);
        chk("s5_d0", q1d[0], 8'h0D);
        chk("s5_cmax", cmax, 1);
        chk("s5_nf_npulse", q2t.size(), 2);
        chk("s5_nf_d0", q2d[0], 8'h0D);
        chk("s5_nf_d1", q2d[1], 8'h0A);
        chk("s5_nf_gap", q2t[1] - q2t[0], 8);

        // 6: flush, then reset, in the middle of a gap
        for (int k = 0; k < 2; k++) begin
            tick(10);
            for (int i = 0; i < 4; i++) drive(8'hB0 + 8'(i), 1, 0, 0);
            chk($sformatf("s6_%0d_count3", k), c1, 3);
            drive(8'hEE, 1, k == 0, k == 1);
            chk($sformatf("s6_%0d_count0", k), c1, 0);
            chk($sformatf("s6_%0d_ovf", k), o1, 0);
            chk($sformatf("s6_%0d_strobe", k), s1, 0);
            if (k == 1) chk("s6_rst_data", d1, 8'h00);
            clr_log();
            tick(20);
            chk($sformatf("s6_%0d_quiet", k), q1t.size(), 0);
            chk($sformatf("s6_%0d_quiet_nf", k), q2t.size(), 0);
        end

        chk("no_back_to_back", dbl, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
